// File: rtl/display_hdmi_frame_fifo_feeder.sv
// Write-side producer for the HDMI pixel FIFO: requests DMA bursts per line
// segment, tags pixels with SOF/EOL and throttles on FIFO occupancy.
module display_hdmi_frame_fifo_feeder #(
    parameter int DATA_WIDTH    = 24,
    parameter int ADDR_WIDTH    = 10,
    parameter int BURST_LEN     = 64,
    parameter int H_ACTIVE      = 1280,
    parameter int V_ACTIVE      = 720,
    parameter int REQ_THRESHOLD = 2**ADDR_WIDTH - BURST_LEN - 2
) (
    input  logic                    i_arst,
    input  logic                    i_wclk,
    input  logic                    i_enable,
    input  logic                    i_frame_start,
    output logic                    o_req,
    input  logic                    i_req_ack,
    output logic [15:0]             o_req_x,
    output logic [15:0]             o_req_y,
    output logic [15:0]             o_req_len,
    input  logic                    i_rd_valid,
    input  logic [DATA_WIDTH-1:0]   i_rd_data,
    output logic                    o_rd_ready,
    output logic                    o_fifo_we,
    output logic [DATA_WIDTH+1:0]   o_fifo_wdata,
    input  logic                    i_fifo_full,
    input  logic [ADDR_WIDTH-1:0]   i_fifo_wcnt,
    output logic                    o_busy,
    output logic                    o_frame_done,
    output logic                    o_ovf_err,
    output logic                    o_sync_err
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_SPACE,
        S_REQ,
        S_XFER,
        S_FRAME_END
    } state_t;

    localparam logic [15:0] L_H_ACTIVE = 16'(H_ACTIVE);
    localparam logic [15:0] L_V_ACTIVE = 16'(V_ACTIVE);
    localparam logic [15:0] L_BURST    = 16'(BURST_LEN);
    localparam logic [31:0] L_THRESH   = 32'(REQ_THRESHOLD);

    state_t                  r_state;
    state_t                  w_next;
    logic                    r_space_ok;
    logic                    r_sof_pending;
    logic [15:0]             r_x;
    logic [15:0]             r_y;
    logic [15:0]             r_beat;
    logic [15:0]             r_req_x;
    logic [15:0]             r_req_y;
    logic [15:0]             r_req_len;
    logic                    r_we;
    logic [DATA_WIDTH+1:0]   r_wdata;
    logic                    r_ovf;
    logic                    r_sync;

    logic                    w_accept;
    logic                    w_last_beat;
    logic                    w_line_end;
    logic                    w_eol;
    logic [15:0]             w_remain;
    logic [15:0]             w_len;
    logic [15:0]             w_x_next;

    assign w_accept    = (r_state == S_XFER) & i_rd_valid & ~i_fifo_full;
    assign w_last_beat = (r_beat == r_req_len - 16'd1);
    assign w_x_next    = r_x + r_req_len;
    assign w_line_end  = (w_x_next == L_H_ACTIVE);
    assign w_eol       = ((r_x + r_beat) == (L_H_ACTIVE - 16'd1));
    assign w_remain    = L_H_ACTIVE - r_x;
    assign w_len       = (w_remain < L_BURST) ? w_remain : L_BURST;

    always_ff @(posedge i_wclk or posedge i_arst) begin
        if (i_arst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_frame_start && i_enable) w_next = S_WAIT_SPACE;
            end
            S_WAIT_SPACE: begin
                // Only a registered space compare lets us leave, even when disabling.
                if (r_space_ok) w_next = i_enable ? S_REQ : S_IDLE;
            end
            S_REQ: begin
                if (i_req_ack) w_next = S_XFER;
            end
            S_XFER: begin
                if (w_accept && w_last_beat) begin
                    if (w_line_end && (r_y == L_V_ACTIVE - 16'd1)) w_next = S_FRAME_END;
                    else                                           w_next = S_WAIT_SPACE;
                end
            end
            S_FRAME_END: w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_wclk or posedge i_arst) begin
        if (i_arst) begin
            r_space_ok    <= 1'b0;
            r_sof_pending <= 1'b0;
            r_x           <= '0;
            r_y           <= '0;
            r_beat        <= '0;
            r_req_x       <= '0;
            r_req_y       <= '0;
            r_req_len     <= '0;
            r_we          <= 1'b0;
            r_wdata       <= '0;
            r_ovf         <= 1'b0;
            r_sync        <= 1'b0;
        end else begin
            r_space_ok <= (32'(i_fifo_wcnt) <= L_THRESH);
            r_we       <= w_accept;
            r_ovf      <= r_ovf | (r_we & i_fifo_full);
            r_sync     <= r_sync | (i_frame_start & (r_state != S_IDLE));

            if (r_state == S_IDLE && i_frame_start && i_enable) begin
                r_x           <= '0;
                r_y           <= '0;
                r_sof_pending <= 1'b1;
            end

            if (r_state == S_WAIT_SPACE && r_space_ok && i_enable) begin
                r_req_x   <= r_x;
                r_req_y   <= r_y;
                r_req_len <= w_len;
            end

            if (r_state == S_REQ && i_req_ack) r_beat <= '0;

            if (w_accept) begin
                r_wdata       <= {w_eol, r_sof_pending, i_rd_data};
                r_sof_pending <= 1'b0;
                r_beat        <= r_beat + 16'd1;
                if (w_last_beat) begin
                    if (w_line_end) begin
                        r_x <= '0;
                        r_y <= r_y + 16'd1;
                    end else begin
                        r_x <= w_x_next;
                    end
                end
            end
        end
    end

    assign o_req        = (r_state == S_REQ);
    assign o_req_x      = r_req_x;
    assign o_req_y      = r_req_y;
    assign o_req_len    = r_req_len;
    assign o_rd_ready   = (r_state == S_XFER) & ~i_fifo_full;
    assign o_fifo_we    = r_we;
    assign o_fifo_wdata = r_wdata;
    assign o_busy       = (r_state != S_IDLE);
    assign o_frame_done = (r_state == S_FRAME_END);
    assign o_ovf_err    = r_ovf;
    assign o_sync_err   = r_sync;
endmodule

// File: tb/tb_display_hdmi_frame_fifo_feeder.sv
// Scoreboard bench for display_hdmi_frame_fifo_feeder: a reactive DMA model
// pushes expected FIFO words on each accepted beat; a monitor pops and compares.
module tb_display_hdmi_frame_fifo_feeder;
    localparam int DW = 24;
    localparam int AW = 4;
    localparam int BL = 4;
    localparam int H  = 10;
    localparam int V  = 2;
    localparam int TH = 10;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] len;
    } req_t;

    logic          clk = 1'b0;
    logic          arst;
    logic          enable;
    logic          frame_start;
    logic          o_req;
    logic          req_ack;
    logic [15:0]   o_req_x;
    logic [15:0]   o_req_y;
    logic [15:0]   o_req_len;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          o_rd_ready;
    logic          o_fifo_we;
    logic [DW+1:0] o_fifo_wdata;
    logic          fifo_full;
    logic [AW-1:0] fifo_wcnt;
    logic          o_busy;
    logic          o_frame_done;
    logic          o_ovf_err;
    logic          o_sync_err;

    always #5 clk = ~clk;

    display_hdmi_frame_fifo_feeder #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .BURST_LEN(BL),
        .H_ACTIVE(H),
        .V_ACTIVE(V),
        .REQ_THRESHOLD(TH)
    ) dut (
        .i_arst(arst),
        .i_wclk(clk),
        .i_enable(enable),
        .i_frame_start(frame_start),
        .o_req(o_req),
        .i_req_ack(req_ack),
        .o_req_x(o_req_x),
        .o_req_y(o_req_y),
        .o_req_len(o_req_len),
        .i_rd_valid(rd_valid),
        .i_rd_data(rd_data),
        .o_rd_ready(o_rd_ready),
        .o_fifo_we(o_fifo_we),
        .o_fifo_wdata(o_fifo_wdata),
        .i_fifo_full(fifo_full),
        .i_fifo_wcnt(fifo_wcnt),
        .o_busy(o_busy),
        .o_frame_done(o_frame_done),
        .o_ovf_err(o_ovf_err),
        .o_sync_err(o_sync_err)
    );

    int tests_run = 0;
    int tests_failed = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    req_t          exp_req[$];
    logic [DW+1:0] exp_wr[$];

    int  wr_cnt = 0;
    int  done_cnt = 0;
    int  frame_pix = 0;
    int  frame_reqs = 0;
    int  req_sum = 0;
    int  beats_left = 0;
    int  acc_in_burst = 0;
    int  ack_delay = 0;
    bit  gap_mode = 0;
    bit  bp_arm = 0;
    int  frame_w0 = 0;
    int  frame_d0 = 0;

    // DMA model
    int            d_waitc = 0;
    bit            d_seen = 0;
    req_t          d_cur;
    req_t          d_exp;
    int            d_prev_len = 0;
    int            d_burst_start = 0;
    int            d_full_cnt = 0;
    bit            d_bp_gap = 0;
    logic [DW-1:0] d_nxt = '0;
    logic          d_sof;
    logic          d_eol;

    initial begin
        req_ack = 1'b0;
        rd_valid = 1'b0;
        rd_data = '0;
        fifo_full = 1'b0;
        forever begin
            @(negedge clk);
            if (arst) begin
                beats_left = 0;
                acc_in_burst = 0;
                d_seen = 0;
                d_waitc = 0;
                d_prev_len = 0;
                d_full_cnt = 0;
                d_bp_gap = 0;
                req_ack = 1'b0;
                rd_valid = 1'b0;
                fifo_full = 1'b0;
            end else begin
                if (d_full_cnt > 0) begin
                    chk("bp_ready_low", 32'(o_rd_ready), 0);
                    chk("bp_no_write", 32'(o_fifo_we), 0);
                end
                if (req_ack) begin
                    req_ack = 1'b0;
                    beats_left = int'(d_cur.len);
                    acc_in_burst = 0;
                    d_seen = 0;
                end else if (o_req) begin
                    if (!d_seen) begin
                        d_seen = 1;
                        d_waitc = 0;
                        if (d_prev_len > 0) chk("burst_writes", 32'(wr_cnt - d_burst_start), 32'(d_prev_len));
                        d_burst_start = wr_cnt;
                        frame_reqs++;
                        d_cur = '{x: o_req_x, y: o_req_y, len: o_req_len};
                        req_sum += int'(o_req_len);
                        d_prev_len = int'(o_req_len);
                        chk("req_avail", 32'(exp_req.size() > 0), 1);
                        if (exp_req.size() > 0) begin
                            d_exp = exp_req.pop_front();
                            chk("req_x", 32'(o_req_x), 32'(d_exp.x));
                            chk("req_y", 32'(o_req_y), 32'(d_exp.y));
                            chk("req_len", 32'(o_req_len), 32'(d_exp.len));
                        end
                    end else begin
                        chk("req_xy_stable", {o_req_x, o_req_y}, {d_cur.x, d_cur.y});
                        chk("req_len_stable", 32'(o_req_len), 32'(d_cur.len));
                    end
                    if (d_waitc >= ack_delay) req_ack = 1'b1;
                    else                      d_waitc++;
                end

                if (bp_arm && beats_left > 0 && acc_in_burst > 0 && d_full_cnt == 0 && !d_bp_gap) begin
                    bp_arm = 0;
                    d_bp_gap = 1;
                    rd_valid = 1'b0;
                end else if (d_bp_gap) begin
                    d_bp_gap = 0;
                    d_full_cnt = 5;
                    fifo_full = 1'b1;
                    rd_valid = (beats_left > 0);
                end else begin
                    if (d_full_cnt > 0) begin
                        d_full_cnt--;
                        if (d_full_cnt == 0) fifo_full = 1'b0;
                    end
                    rd_valid = (beats_left > 0) && (!gap_mode || $urandom_range(0, 1) == 1);
                end
                rd_data = d_nxt;

                #1;
                if (rd_valid && o_rd_ready) begin
                    d_sof = (frame_pix == 0);
                    d_eol = ((frame_pix % H) == H - 1);
                    exp_wr.push_back({d_eol, d_sof, d_nxt});
                    frame_pix++;
                    d_nxt = d_nxt + 1'b1;
                    beats_left--;
                    acc_in_burst++;
                end
            end
        end
    end

    // FIFO write monitor
    bit            m_prev_done = 0;
    logic [DW+1:0] m_exp;
    initial begin
        forever begin
            @(negedge clk);
            if (m_prev_done) chk("busy_after_done", 32'(o_busy), 0);
            m_prev_done = o_frame_done;
            if (o_frame_done) done_cnt++;
            if (o_fifo_we) begin
                wr_cnt++;
                chk("wr_avail", 32'(exp_wr.size() > 0), 1);
                if (exp_wr.size() > 0) begin
                    m_exp = exp_wr.pop_front();
                    chk("wr_data", 32'(o_fifo_wdata), 32'(m_exp));
                end
            end
        end
    end

    task automatic start_frame();
        req_t r;
        frame_pix = 0;
        frame_reqs = 0;
        req_sum = 0;
        frame_w0 = wr_cnt;
        frame_d0 = done_cnt;
        for (int yy = 0; yy < V; yy++) begin
            for (int xx = 0; xx < H; xx += BL) begin
                r.x = 16'(xx);
                r.y = 16'(yy);
                r.len = 16'((H - xx < BL) ? (H - xx) : BL);
                exp_req.push_back(r);
            end
        end
        @(posedge clk); #1;
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            if (!o_busy) break;
        end
        chk({tag, "_idle"}, 32'(o_busy), 0);
        @(posedge clk); #1;
    endtask

    task automatic finish_frame(input string tag, input int exp_writes, input int exp_done);
        wait_idle(tag);
        chk({tag, "_writes"}, 32'(wr_cnt - frame_w0), 32'(exp_writes));
        chk({tag, "_done"}, 32'(done_cnt - frame_d0), 32'(exp_done));
        chk({tag, "_wq_empty"}, 32'(exp_wr.size()), 0);
    endtask

    task automatic check_rst(input string tag);
        chk({tag, "_ctl"}, {25'd0, o_req, o_rd_ready, o_fifo_we, o_busy, o_frame_done, o_ovf_err, o_sync_err}, 0);
        chk({tag, "_xy"}, {o_req_x, o_req_y}, 0);
        chk({tag, "_len"}, 32'(o_req_len), 0);
        chk({tag, "_wdata"}, 32'(o_fifo_wdata), 0);
    endtask

    bit saw_req;

    initial begin
        arst = 1'b1;
        enable = 1'b0;
        frame_start = 1'b0;
        fifo_wcnt = '0;
        repeat (3) @(posedge clk);
        #1;
        check_rst("reset");
        arst = 1'b0;
        @(posedge clk); #1;
        enable = 1'b1;

        // full-rate single frame
        start_frame();
        finish_frame("f1", 20, 1);
        chk("f1_req_q_empty", 32'(exp_req.size()), 0);

        // space throttle
        fifo_wcnt = 4'd11;
        start_frame();
        repeat (20) @(posedge clk);
        #1;
        chk("thr_hold_req", 32'(o_req), 0);
        chk("thr_busy", 32'(o_busy), 1);
        fifo_wcnt = 4'd10;
        @(posedge clk); #1;
        chk("thr_req_lat1", 32'(o_req), 0);
        @(posedge clk); #1;
        chk("thr_req_lat2", 32'(o_req), 1);
        finish_frame("thr", 20, 1);
        fifo_wcnt = '0;

        // backpressure plus slow ack
        ack_delay = 7;
        bp_arm = 1;
        start_frame();
        finish_frame("bp", 20, 1);
        chk("bp_fired", 32'(bp_arm), 0);
        chk("bp_ovf", 32'(o_ovf_err), 0);

        // valid gaps plus frame_start during transfer
        ack_delay = 2;
        gap_mode = 1;
        chk("sync_pre", 32'(o_sync_err), 0);
        start_frame();
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk); #1;
            if (frame_reqs == 3 && beats_left > 0) break;
        end
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        chk("sync_err", 32'(o_sync_err), 1);
        finish_frame("gap", 20, 1);
        gap_mode = 0;
        ack_delay = 0;

        // enable drop mid-line
        start_frame();
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk); #1;
            if (frame_reqs == 2 && acc_in_burst == 1) break;
        end
        enable = 1'b0;
        finish_frame("en", 8, 0);
        chk("en_reqs", 32'(frame_reqs), 2);
        chk("en_req_sum", 32'(req_sum), 8);
        saw_req = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (o_req || o_busy) saw_req = 1;
        end
        chk("en_no_req", 32'(saw_req), 0);
        exp_req.delete();
        enable = 1'b1;

        // reset during burst beat 2, then clean restart
        start_frame();
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk); #1;
            if (frame_reqs == 2 && acc_in_burst == 2 && beats_left > 0) break;
        end
        chk("rst_beat2", 32'(acc_in_burst), 2);
        arst = 1'b1;
        #1;
        check_rst("midrst");
        @(posedge clk); #1;
        exp_wr.delete();
        exp_req.delete();
        @(posedge clk); #1;
        arst = 1'b0;
        @(posedge clk); #1;
        start_frame();
        finish_frame("restart", 20, 1);
        chk("restart_sync", 32'(o_sync_err), 0);
        chk("end_req_q_empty", 32'(exp_req.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
